// File: rtl/fdmas_pkg.sv
// Shared widths, saturation limits and helpers for the F-DMAS pixel beamformer.
// Optional bf_valid output is enabled with the FDMAS_VALID_OUT_EN macro.
package fdmas_pkg;

   localparam int DATA_W = 16;
   localparam int OUT_W  = 17;
   localparam int ABS_W  = 17;
   localparam int SQRT_W = 9;
   localparam int S1_W   = 16;
   localparam int S2_W   = 24;
   localparam int PROD_W = 30;
   localparam int DIFF_W = 31;
   localparam int REM_W  = 12;

   localparam logic signed [OUT_W-1:0] OUT_MAX = 17'h0_FFFF;
   localparam logic signed [OUT_W-1:0] OUT_MIN = 17'h1_0000;

   typedef struct packed {
      logic              vld;
      logic              neg;
      logic [ABS_W-1:0]  mag;
      logic [SQRT_W-1:0] root;
   } sqrt_tok_t;

   // Widened magnitude so that -32768 maps to +32768 without overflow.
   function automatic logic [ABS_W-1:0] abs_val(input logic signed [DATA_W-1:0] s);
      logic [ABS_W-1:0] ext;
      ext = {s[DATA_W-1], s};
      return s[DATA_W-1] ? (~ext + 17'd1) : ext;
   endfunction

endpackage

// File: rtl/fdmas_sqrt_pipe.sv
// Pipelined floor square root (digit-by-digit, shift/subtract) of a 17-bit magnitude.
// The nine result bits are spread over exactly SQRT_LATENCY register stages.
module fdmas_sqrt_pipe
   import fdmas_pkg::*;
#(
   parameter int SQRT_LATENCY = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld_i,
   input  logic             neg_i,
   input  logic [ABS_W-1:0] mag_i,
   output sqrt_tok_t        tok_o
);

   genvar s;
   generate
      for (s = 0; s < SQRT_LATENCY; s++) begin : g_stage
         localparam int LO = (s * SQRT_W) / SQRT_LATENCY;
         localparam int HI = ((s + 1) * SQRT_W) / SQRT_LATENCY;

         sqrt_tok_t             tok_in_s, tok_d, tok_q;
         logic [REM_W-1:0]      rem_in_s, rem_d, rem_t, trial_t;
         logic [2*SQRT_W-1:0]   mag_pad_s;

         if (s == 0) begin : g_src
            assign tok_in_s = '{vld: vld_i, neg: neg_i, mag: mag_i, root: '0};
            assign rem_in_s = '0;
         end else begin : g_chain
            assign tok_in_s = g_stage[s-1].tok_q;
            assign rem_in_s = g_stage[s-1].g_rem.rem_q;
         end

         assign mag_pad_s = {1'b0, tok_in_s.mag};

         // Result bits LO..HI-1, most significant pair of the magnitude first.
         always_comb begin
            tok_d   = tok_in_s;
            rem_d   = rem_in_s;
            rem_t   = '0;
            trial_t = '0;
            for (int k = LO; k < HI; k++) begin
               rem_t   = {rem_d[REM_W-3:0], mag_pad_s[2*(SQRT_W-1-k) +: 2]};
               trial_t = {1'b0, tok_d.root, 2'b01};
               if (rem_t >= trial_t) begin
                  rem_d      = rem_t - trial_t;
                  tok_d.root = {tok_d.root[SQRT_W-2:0], 1'b1};
               end else begin
                  rem_d      = rem_t;
                  tok_d.root = {tok_d.root[SQRT_W-2:0], 1'b0};
               end
            end
         end

         // Stage token register.
         always_ff @(posedge clk) begin
            if (rst) tok_q <= '0;
            else     tok_q <= tok_d;
         end

         // The partial remainder is only needed by a following stage.
         if (s < SQRT_LATENCY - 1) begin : g_rem
            logic [REM_W-1:0] rem_q;
            always_ff @(posedge clk) begin
               if (rst) rem_q <= '0;
               else     rem_q <= rem_d;
            end
         end
      end
   endgenerate

   assign tok_o = g_stage[SQRT_LATENCY-1].tok_q;

endmodule

// File: rtl/factor_dmas.sv
// Pixel-level factorized DMAS core: y = ((sum s_hat)^2 - sum|s|) >>> OUT_SHIFT, saturated.
// Define FDMAS_VALID_OUT_EN to add the bf_valid output.
module factor_dmas
   import fdmas_pkg::*;
#(
   parameter int CHANNELS     = 128,
   parameter int SQRT_LATENCY = 5,
   parameter int OUT_SHIFT    = 13
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] rfdata,
   output logic signed [OUT_W-1:0]  bf_out
`ifdef FDMAS_VALID_OUT_EN
   ,
   output logic                     bf_valid
`endif
);

   // Output register loads when the pre-edge count equals DONE_CNT (edge CHANNELS+SQRT_LATENCY+4).
   localparam int DONE_CNT = CHANNELS + SQRT_LATENCY + 3;
   localparam int CNT_W    = $clog2(DONE_CNT + 2);
   localparam logic signed [DIFF_W-1:0] SAT_HI = {{(DIFF_W-OUT_W){OUT_MAX[OUT_W-1]}}, OUT_MAX};
   localparam logic signed [DIFF_W-1:0] SAT_LO = {{(DIFF_W-OUT_W){OUT_MIN[OUT_W-1]}}, OUT_MIN};

   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     cap_vld_q, cap_vld_d, cap_neg_q, cap_neg_d;
   logic [ABS_W-1:0]         cap_mag_q, cap_mag_d;
   logic signed [S1_W-1:0]   s1_q, s1_d, shat_s;
   logic [S2_W-1:0]          s2_q, s2_d;
   logic [PROD_W-1:0]        prod_q, prod_d;
   logic signed [OUT_W-1:0]  bf_out_q, bf_out_d, sat_s;
   logic signed [2*S1_W-1:0] sq_s;
   logic signed [DIFF_W-1:0] diff_s, shifted_s;
   logic                     in_win_s, done_s;
   sqrt_tok_t                tok_s;

   fdmas_sqrt_pipe #(.SQRT_LATENCY(SQRT_LATENCY)) u_sqrt (
      .clk   (clk),
      .rst   (rst),
      .vld_i (cap_vld_q),
      .neg_i (cap_neg_q),
      .mag_i (cap_mag_q),
      .tok_o (tok_s)
   );

   assign in_win_s = (cnt_q >= CNT_W'(1)) && (cnt_q <= CNT_W'(CHANNELS));
   assign done_s   = (cnt_q == CNT_W'(DONE_CNT));

   // Capture, accumulate, square and saturate datapath.
   always_comb begin
      cnt_d     = (cnt_q == CNT_W'(DONE_CNT + 1)) ? cnt_q : cnt_q + CNT_W'(1);
      cap_vld_d = in_win_s;
      cap_neg_d = in_win_s & rfdata[DATA_W-1];
      cap_mag_d = in_win_s ? abs_val(rfdata) : '0;

      shat_s = tok_s.neg ? -S1_W'(tok_s.root) : S1_W'(tok_s.root);
      if (tok_s.vld) begin
         s1_d = s1_q + shat_s;
         s2_d = s2_q + S2_W'(tok_s.mag);
      end else begin
         s1_d = s1_q;
         s2_d = s2_q;
      end

      sq_s   = s1_q * s1_q;
      prod_d = sq_s[PROD_W-1:0];

      diff_s    = $signed({1'b0, prod_q}) - $signed({{(DIFF_W-S2_W){1'b0}}, s2_q});
      shifted_s = diff_s >>> OUT_SHIFT;
      if (shifted_s > SAT_HI) begin
         sat_s = OUT_MAX;
      end else if (shifted_s < SAT_LO) begin
         sat_s = OUT_MIN;
      end else begin
         sat_s = shifted_s[OUT_W-1:0];
      end
      bf_out_d = done_s ? sat_s : bf_out_q;
   end

   // Frame state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         cap_vld_q <= 1'b0;
         cap_neg_q <= 1'b0;
         cap_mag_q <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         prod_q    <= '0;
         bf_out_q  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         cap_vld_q <= cap_vld_d;
         cap_neg_q <= cap_neg_d;
         cap_mag_q <= cap_mag_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         prod_q    <= prod_d;
         bf_out_q  <= bf_out_d;
      end
   end

   assign bf_out = bf_out_q;

`ifdef FDMAS_VALID_OUT_EN
   logic valid_q, valid_d;

   assign valid_d = valid_q | done_s;

   // Sticky result-valid flag.
   always_ff @(posedge clk) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= valid_d;
   end

   assign bf_valid = valid_q;
`endif

endmodule

// File: tb/tb_factor_dmas.sv
// Randomized and directed frames checked against a behavioural F-DMAS reference model.
module tb_factor_dmas;

   localparam int C        = 128;
   localparam int L        = 5;
   localparam int EDGE_OUT = C + L + 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [15:0] rfdata = 16'sd0;
   logic signed [16:0] bf_out, bf_out8;
`ifdef FDMAS_VALID_OUT_EN
   logic               bf_valid, bf_valid8;
`endif

   int errors = 0;
   int checks = 0;
   logic signed [15:0] smp [C];

   always #5 clk = ~clk;

   factor_dmas #(.CHANNELS(C), .SQRT_LATENCY(L), .OUT_SHIFT(13)) dut (
      .clk      (clk),
      .rst      (rst),
      .rfdata   (rfdata),
`ifdef FDMAS_VALID_OUT_EN
      .bf_valid (bf_valid),
`endif
      .bf_out   (bf_out)
   );

   factor_dmas #(.CHANNELS(C), .SQRT_LATENCY(L), .OUT_SHIFT(8)) dut8 (
      .clk      (clk),
      .rst      (rst),
      .rfdata   (rfdata),
`ifdef FDMAS_VALID_OUT_EN
      .bf_valid (bf_valid8),
`endif
      .bf_out   (bf_out8)
   );

   task automatic check_val(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: integer sqrt by search, plain sums, floor shift, clamp.
   function automatic longint model(input int shift);
      longint s1 = 0;
      longint s2 = 0;
      longint d, y;
      int a, r;
      for (int i = 0; i < C; i++) begin
         a = (smp[i] < 0) ? -int'(smp[i]) : int'(smp[i]);
         r = 0;
         while ((r + 1) * (r + 1) <= a) r++;
         s1 += (smp[i] < 0) ? -r : r;
         s2 += a;
      end
      d = s1 * s1 - s2;
      y = d >>> shift;
      if (y > 65535)  y = 65535;
      if (y < -65536) y = -65536;
      return y;
   endfunction

   task automatic fill_const(input logic signed [15:0] v);
      for (int i = 0; i < C; i++) smp[i] = v;
   endtask

   task automatic run_frame(input string name);
      longint e13, e8;
      e13 = model(13);
      e8  = model(8);
      rst    = 1'b1;
      rfdata = 16'($urandom);
      @(posedge clk); #1;
      check_val({name, "/rst_out"}, bf_out, 0);
`ifdef FDMAS_VALID_OUT_EN
      check_val({name, "/rst_valid"}, bf_valid, 0);
`endif
      rst = 1'b0;
      for (int k = 1; k <= EDGE_OUT + 3; k++) begin
         if (k >= 2 && k <= C + 1) rfdata = smp[k-2];
         else                      rfdata = 16'($urandom);
         @(posedge clk); #1;
         if (k == EDGE_OUT - 1) begin
            check_val({name, "/pre_out"}, bf_out, 0);
            check_val({name, "/pre_out8"}, bf_out8, 0);
`ifdef FDMAS_VALID_OUT_EN
            check_val({name, "/pre_valid"}, bf_valid, 0);
`endif
         end
         if (k == EDGE_OUT) begin
            check_val({name, "/out"}, bf_out, e13);
            check_val({name, "/out8"}, bf_out8, e8);
`ifdef FDMAS_VALID_OUT_EN
            check_val({name, "/valid"}, bf_valid, 1);
            check_val({name, "/valid8"}, bf_valid8, 1);
`endif
         end
         if (k == EDGE_OUT + 3) begin
            check_val({name, "/hold"}, bf_out, e13);
`ifdef FDMAS_VALID_OUT_EN
            check_val({name, "/hold_valid"}, bf_valid, 1);
`endif
         end
      end
   endtask

   // Starts a frame of large samples and leaves it after edge 59 so the next reset lands on edge 60.
   task automatic start_aborted_frame();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 1; k <= 59; k++) begin
         rfdata = 16'sd32767;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      fill_const(16'sd4);      run_frame("all4");
      fill_const(16'sd10000);  run_frame("all10000");
      for (int i = 0; i < C; i++) smp[i] = (i % 2 == 0) ? 16'sd100 : -16'sd100;
      run_frame("alt100");
      fill_const(16'sd0); smp[0] = 16'sd32767;       run_frame("first_max");
      fill_const(16'sd0); smp[C-1] = 16'h8000;       run_frame("last_min");
      fill_const(16'sd32767);  run_frame("all_max");

      start_aborted_frame();
      fill_const(16'sd4);      run_frame("abort_all4");

      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < C; i++) smp[i] = 16'($urandom);
         run_frame("rand_full");
      end
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < C; i++) smp[i] = 16'($urandom_range(0, 32767));
         run_frame("rand_pos");
      end
      for (int i = 0; i < C; i++) smp[i] = 16'($urandom_range(0, 600)) - 16'sd300;
      run_frame("rand_small");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
